fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the program counter and sequences the synchronous, active-low-enabled instruction ROM. It issues one read per instruction, captures the ROM word in the only cycle it is valid, and presents it to decode through a valid/ready handshake. It also takes PC redirects for jumps and branches, with flush of any in-flight fetch, and a halt request. It sits between the ROM and the decode/control stage of the MIPS core.

---
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, sequences a synchronous active-low-enabled ROM
// and hands fetched words to decode over valid/ready. Optional macro: FETCH_ALIGN_CHECK_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h00400000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_rd_n,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        ins_ready,
    output logic        ins_valid,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc,
    output logic        busy,
    output logic        align_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_HOLD,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ins_valid_q, ins_valid_d;
    logic [31:0] ins_data_q, ins_data_d;
    logic [31:0] ins_pc_q, ins_pc_d;

    logic        redirect_taken;
    logic [31:0] redirect_target;
    state_t      resume_state;

    // Redirects are not honoured in IDLE: the PC is still settling out of reset there.
    assign redirect_taken = redirect && (state_q != S_IDLE);
    assign resume_state   = halt ? S_HALT : S_REQ;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [31:0] EXC_VECTOR = 32'h80000180;

    logic redirect_misaligned;
    logic align_err_q, align_err_d;

    assign redirect_misaligned = |redirect_pc[1:0];
    assign redirect_target     = redirect_misaligned ? EXC_VECTOR : redirect_pc;
    assign align_err_d         = redirect_taken && redirect_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end

    assign align_err = align_err_q;
`else
    logic unused_redirect_lsbs;

    // Without the check a misaligned target is silently word-aligned.
    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign align_err            = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_valid_d = ins_valid_q;
        ins_data_d  = ins_data_q;
        ins_pc_d    = ins_pc_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = resume_state;
            end
            S_REQ: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                // mem_data is only valid in this cycle, so it is captured unconditionally here.
                ins_data_d  = mem_data;
                ins_pc_d    = pc_q;
                ins_valid_d = 1'b1;
                pc_d        = pc_q + 32'd4;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (ins_valid_q && ins_ready) begin
                    ins_valid_d = 1'b0;
                    state_d     = resume_state;
                end
            end
            S_HALT: begin
                if (!halt) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect overrides everything above; a HOLD handshake in the same cycle
        // has already consumed the word, so dropping ins_valid loses nothing.
        if (redirect_taken) begin
            pc_d        = redirect_target;
            ins_valid_d = 1'b0;
            ins_data_d  = ins_data_q;
            ins_pc_d    = ins_pc_q;
            state_d     = resume_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            ins_valid_q <= 1'b0;
            ins_data_q  <= 32'd0;
            ins_pc_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_valid_q <= ins_valid_d;
            ins_data_q  <= ins_data_d;
            ins_pc_q    <= ins_pc_d;
        end
    end

    assign mem_rd_n  = (state_q != S_REQ);
    assign mem_addr  = pc_q;
    assign busy      = (state_q == S_REQ) || (state_q == S_RESP);
    assign ins_valid = ins_valid_q;
    assign ins_data  = ins_data_q;
    assign ins_pc    = ins_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: ROM model, transaction-level instruction-stream model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h00400000;
    localparam logic [31:0] EXC_VECTOR = 32'h80000180;

    logic        clk;
    logic        rst_n;
    logic        mem_rd_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        ins_ready;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        busy;
    logic        align_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] rom_q;
    logic [31:0] exp_pc;
    logic        exp_align;
    logic [31:0] hs_pc_q[$];
    logic [31:0] hs_data_q[$];
    int          hs_cyc_q[$];

    fetch_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_rd_n   (mem_rd_n),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .ins_ready  (ins_ready),
        .ins_valid  (ins_valid),
        .ins_data   (ins_data),
        .ins_pc     (ins_pc),
        .busy       (busy),
        .align_err  (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h00400000) return 32'h02328020;
        if (a == 32'h00400004) return 32'h001140C0;
        return {a[15:0] ^ 16'hC3A5, a[31:16]};
    endfunction

    function automatic logic [31:0] redirect_dest(input logic [31:0] p);
`ifdef FETCH_ALIGN_CHECK_EN
        return (p[1:0] != 2'b00) ? EXC_VECTOR : p;
`else
        return {p[31:2], 2'b00};
`endif
    endfunction

    // Synchronous ROM: word appears the cycle after a read, zero otherwise.
    always @(posedge clk) rom_q <= (!mem_rd_n) ? rom_word(mem_addr) : 32'd0;
    assign mem_data = rom_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Model: the delivered stream is consecutive words from exp_pc; a handshake
    // advances it by 4, a redirect restarts it at the (possibly corrected) target.
    initial begin
        exp_pc    = RESET_PC;
        exp_align = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_pc    = RESET_PC;
                exp_align = 1'b0;
            end else begin
                if (ins_valid) begin
                    chk("model ins_pc", ins_pc, exp_pc);
                    chk("model ins_data", ins_data, rom_word(exp_pc));
                    chk("model busy in hold", {31'd0, busy}, 32'd0);
                end
                if (!mem_rd_n) begin
                    chk("model mem_addr", mem_addr, exp_pc);
                    chk("model busy on read", {31'd0, busy}, 32'd1);
                end
                chk("model align_err", {31'd0, align_err}, {31'd0, exp_align});
                exp_align = 1'b0;
                if (ins_valid && ins_ready) begin
                    hs_pc_q.push_back(ins_pc);
                    hs_data_q.push_back(ins_data);
                    hs_cyc_q.push_back(cyc);
                    exp_pc = exp_pc + 32'd4;
                end
                if (redirect) begin
                    exp_pc = redirect_dest(redirect_pc);
`ifdef FETCH_ALIGN_CHECK_EN
                    exp_align = (redirect_pc[1:0] != 2'b00);
`endif
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 60 && ins_valid !== 1'b1; k++) step();
        if (ins_valid !== 1'b1) chk({name, " valid timeout"}, {31'd0, ins_valid}, 32'd1);
    endtask

    task automatic wait_rd(input string name);
        for (int k = 0; k < 60 && mem_rd_n !== 1'b0; k++) step();
        if (mem_rd_n !== 1'b0) chk({name, " read timeout"}, {31'd0, mem_rd_n}, 32'd0);
    endtask

    task automatic wait_hs(input string name, input int n);
        for (int k = 0; k < 60 && hs_pc_q.size() < n; k++) step();
        if (hs_pc_q.size() < n) chk({name, " handshake timeout"}, 32'(hs_pc_q.size()), 32'(n));
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst_n       = 1'b0;
        halt        = 1'b0;
        ins_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset mem_rd_n", {31'd0, mem_rd_n}, 32'd1);
        chk("reset mem_addr", mem_addr, RESET_PC);
        chk("reset ins_valid", {31'd0, ins_valid}, 32'd0);
        chk("reset ins_data", ins_data, 32'd0);
        chk("reset ins_pc", ins_pc, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset align_err", {31'd0, align_err}, 32'd0);
        #1;
        rst_n = 1'b1;
        chk("idle no read", {31'd0, mem_rd_n}, 32'd1);
        @(posedge clk);
        #1;
        chk("first read cycle", {31'd0, mem_rd_n}, 32'd0);
        chk("first read addr", mem_addr, RESET_PC);
        #1;

        // Back-to-back fetches with ins_ready held high
        wait_hs("stream", 2);
        if (hs_pc_q.size() >= 2) begin
            chk("hs0 pc", hs_pc_q[0], 32'h00400000);
            chk("hs0 data", hs_data_q[0], 32'h02328020);
            chk("hs1 pc", hs_pc_q[1], 32'h00400004);
            chk("hs1 data", hs_data_q[1], 32'h001140C0);
            chk("hs spacing", 32'(hs_cyc_q[1] - hs_cyc_q[0]), 32'd3);
        end

        // Stall in HOLD for 5 cycles
        ins_ready = 1'b0;
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            chk("stall valid", {31'd0, ins_valid}, 32'd1);
            chk("stall pc", ins_pc, 32'h00400008);
            chk("stall data", ins_data, rom_word(32'h00400008));
            chk("stall no read", {31'd0, mem_rd_n}, 32'd1);
            chk("stall next pc", mem_addr, 32'h0040000C);
            step();
        end
        ins_ready = 1'b1;
        wait_hs("stall release", 3);

        // Redirect during RESP drops the captured word
        wait_rd("resp redirect");
        step();
        chk("in resp busy", {31'd0, busy}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'hAAAAAAA8;
        @(posedge clk);
        #1;
        chk("resp redirect dropped", {31'd0, ins_valid}, 32'd0);
        chk("resp redirect rd", {31'd0, mem_rd_n}, 32'd0);
        chk("resp redirect addr", mem_addr, 32'hAAAAAAA8);
        #1;
        redirect = 1'b0;
        wait_hs("resp redirect", 4);
        if (hs_pc_q.size() >= 4) chk("resp redirect ins_pc", hs_pc_q[3], 32'hAAAAAAA8);

        // Halt raised in HOLD, then handshake
        ins_ready = 1'b0;
        wait_valid("halt");
        halt = 1'b1;
        step();
        ins_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("halt entered rd", {31'd0, mem_rd_n}, 32'd1);
        chk("halt entered busy", {31'd0, busy}, 32'd0);
        chk("halt entered valid", {31'd0, ins_valid}, 32'd0);
        #1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("halted no read", {31'd0, mem_rd_n}, 32'd1);
        end
        halt = 1'b0;
        @(posedge clk);
        #1;
        chk("resume rd", {31'd0, mem_rd_n}, 32'd0);
        chk("resume addr", mem_addr, 32'hAAAAAAB0);
        #1;

        // Redirect while halted
        halt = 1'b1;
        repeat (6) step();
        chk("halt2 rd", {31'd0, mem_rd_n}, 32'd1);
        chk("halt2 busy", {31'd0, busy}, 32'd0);
        pulse_redirect(32'h00002000);
        for (int i = 0; i < 3; i++) begin
            chk("halt redirect no read", {31'd0, mem_rd_n}, 32'd1);
            step();
        end
        halt = 1'b0;
        @(posedge clk);
        #1;
        chk("halt redirect addr", mem_addr, 32'h00002000);
        chk("halt redirect rd", {31'd0, mem_rd_n}, 32'd0);
        #1;

        // Redirect coinciding with a HOLD handshake
        wait_valid("hs+redirect");
        base = hs_pc_q.size();
        redirect    = 1'b1;
        redirect_pc = 32'h00003000;
        @(posedge clk);
        #1;
        chk("hs+redirect addr", mem_addr, 32'h00003000);
        chk("hs+redirect valid", {31'd0, ins_valid}, 32'd0);
        #1;
        redirect = 1'b0;
        chk("hs+redirect consumed", 32'(hs_pc_q.size()), 32'(base + 1));
        if (hs_pc_q.size() > base) chk("hs+redirect word", hs_pc_q[base], 32'h00002000);
        wait_hs("hs+redirect", base + 2);
        if (hs_pc_q.size() > base + 1) chk("hs+redirect next", hs_pc_q[base + 1], 32'h00003000);

        // PC wrap-around
        pulse_redirect(32'hFFFFFFFC);
        base = hs_pc_q.size();
        wait_hs("wrap", base + 1);
        if (hs_pc_q.size() > base) chk("wrap word pc", hs_pc_q[base], 32'hFFFFFFFC);
        wait_rd("wrap");
        chk("wrap next addr", mem_addr, 32'h00000000);
        wait_hs("wrap next", base + 2);
        if (hs_pc_q.size() > base + 1) chk("wrap next pc", hs_pc_q[base + 1], 32'h00000000);

        // Misaligned redirect
        redirect    = 1'b1;
        redirect_pc = 32'h00400002;
        @(posedge clk);
        #1;
        chk("misaligned rd", {31'd0, mem_rd_n}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misaligned addr", mem_addr, EXC_VECTOR);
        chk("misaligned align_err", {31'd0, align_err}, 32'd1);
`else
        chk("misaligned addr", mem_addr, 32'h00400000);
        chk("misaligned align_err", {31'd0, align_err}, 32'd0);
`endif
        #1;
        redirect = 1'b0;
        @(posedge clk);
        #1;
        chk("align_err one cycle", {31'd0, align_err}, 32'd0);
        #1;

        // Asynchronous reset in the middle of a fetch
        wait_rd("mid reset");
        base = hs_pc_q.size();
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid reset rd", {31'd0, mem_rd_n}, 32'd1);
        chk("mid reset busy", {31'd0, busy}, 32'd0);
        chk("mid reset addr", mem_addr, RESET_PC);
        chk("mid reset valid", {31'd0, ins_valid}, 32'd0);
        chk("mid reset ins_pc", ins_pc, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        wait_hs("after reset", base + 1);
        if (hs_pc_q.size() > base) chk("after reset pc", hs_pc_q[base], 32'h00400000);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
